afifo_rd_stream: RTL and testbench

Read-side consumer for the async FIFO, clocked on the FIFO read clock. It issues `pop` only when it can guarantee space for the returning word, absorbs the one-clock RAM read latency in a small skid buffer, and presents a standard valid/ready stream downstream. It also provides a flush mode that drains and discards FIFO contents, and a saturating delivered-word counter.

---
 rtl/afifo_rd_stream.sv | 118 +++++++++++
 tb/tb_afifo_rd_stream.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_rd_stream.sv
// Read-side consumer for the async FIFO: credit-checked pops, a small skid buffer that
// absorbs the RAM read latency, a valid/ready output stream, a flush/drain mode and a delivered-word counter.
//
//   state | meaning
//   RUN   | normal streaming, pop only when the returning word has a slot
//   FLUSH | pop everything, discard returning words, output stream idle
//   DONE  | one-cycle flush_done pulse, then RUN or FLUSH again
module afifo_rd_stream #(
    parameter int DW         = 24,
    parameter int SKID_DEPTH = 2,
    parameter int CW         = 16
) (
    input  logic          rclk,
    input  logic          rst_n,
    input  logic          empty,
    input  logic          vld,
    input  logic [DW-1:0] data_out,
    output logic          pop,
    input  logic          flush,
    output logic          flush_done,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] word_cnt
);
    localparam int IW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int NW = $clog2(SKID_DEPTH + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(SKID_DEPTH - 1);
    localparam logic [NW-1:0] FULL     = NW'(SKID_DEPTH);
    localparam logic [NW:0]   DEPTH_X  = (NW + 1)'(SKID_DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          inflight;
    logic [NW-1:0] cnt;
    logic [IW-1:0] rd_idx, wr_idx;
    logic [DW-1:0] mem [SKID_DEPTH];
    logic          deq, wr_en, flush_entry;
    logic [NW:0]   occ;

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    assign out_vld     = (cnt != '0);
    assign out_data    = mem[rd_idx];
    assign deq         = out_vld && out_rdy;
    assign flush_entry = (state == RUN) && flush;
    // inflight qualifies vld so a word from a pop issued before reset is ignored
    assign wr_en       = vld && inflight && (state == RUN) && !flush && ((cnt != FULL) || deq);
    assign occ         = {1'b0, cnt} + (NW + 1)'(inflight) - (NW + 1)'(deq);

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (flush) state_nxt = FLUSH;
            FLUSH:   if (empty && !inflight) state_nxt = DONE;
            DONE:    state_nxt = flush ? FLUSH : RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        flush_done = 1'b0;
        case (state)
            RUN:     pop = !empty && (occ < DEPTH_X);
            FLUSH:   pop = !empty;
            DONE:    flush_done = 1'b1;
            default: pop = 1'b0;
        endcase
        pop = pop && rst_n;
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            cnt      <= '0;
            rd_idx   <= '0;
            wr_idx   <= '0;
            word_cnt <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
        end else begin
            inflight <= pop;
            if (deq && (word_cnt != '1)) word_cnt <= word_cnt + 1'b1;
            if (flush_entry) begin
                cnt    <= '0;
                rd_idx <= '0;
                wr_idx <= '0;
            end else begin
                if (wr_en) begin
                    mem[wr_idx] <= data_out;
                    wr_idx      <= idx_inc(wr_idx);
                end
                if (deq) rd_idx <= idx_inc(rd_idx);
                case ({wr_en, deq})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    overflow_chk: assert property (@(posedge rclk) disable iff (!rst_n)
        !((state == RUN) && vld && inflight && (cnt == FULL) && !deq));

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Bench for afifo_rd_stream: a queue-based FIFO model plus a transaction-level
// reference (loaded order, pop-to-valid latency, outstanding credit) checked every cycle.
module tb_afifo_rd_stream;
    localparam int DW   = 24;
    localparam int SD   = 2;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          rclk, rst_n, empty, vld, pop, flush, flush_done, out_vld, out_rdy;
    logic [DW-1:0] data_out, out_data;
    logic [CW-1:0] word_cnt;

    afifo_rd_stream #(.DW(DW), .SKID_DEPTH(SD), .CW(CW)) dut (
        .rclk(rclk), .rst_n(rst_n), .empty(empty), .vld(vld), .data_out(data_out),
        .pop(pop), .flush(flush), .flush_done(flush_done), .out_vld(out_vld),
        .out_rdy(out_rdy), .out_data(out_data), .word_cnt(word_cnt)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pend_data;
    bit  pend_vld, flushing, flush_req;
    int  n_chk, n_fail, cyc;
    int  popped_ready, popped_total, delivered, total_del, pop_d1;
    int  first_pop, first_ovld, first_xfer, last_xfer, last_vld_cyc, done_cyc, done_cnt;
    int  n_pops, rdy_mode, rdy_limit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        fifo_q.delete();
        exp_q.delete();
        pend_vld = 0; flushing = 0;
        popped_ready = 0; popped_total = 0; delivered = 0; pop_d1 = 0;
        first_pop = -1; first_ovld = -1; first_xfer = -1; last_xfer = -1;
        last_vld_cyc = -1; done_cyc = -1; done_cnt = 0;
    endtask

    task automatic load(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        if (!flushing) exp_q.push_back(w);
    endtask

    task automatic cycle();
        @(negedge rclk);
        cyc++;
        vld      = pend_vld;
        data_out = pend_vld ? pend_data : '0;
        if (pend_vld) last_vld_cyc = cyc;
        pend_vld = 0;
        empty    = (fifo_q.size() == 0);
        case (rdy_mode)
            0:       out_rdy = 1'b1;
            1:       out_rdy = 1'b0;
            2:       out_rdy = cyc[0];
            3:       out_rdy = 1'($urandom_range(0, 1));
            default: out_rdy = (total_del < rdy_limit);
        endcase
        flush = flush_req;
        #1;
        check("pop_vs_empty", pop & empty, 0);
        check("word_cnt", word_cnt, (total_del > CMAX) ? CMAX : total_del);
        if (!flushing) begin
            // a word popped at cycle t is visible downstream from t+2 until taken
            check("out_vld", out_vld, popped_ready > delivered);
            check("flush_done_run", flush_done, 0);
            if (out_vld && exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
            if (out_vld && first_ovld < 0) first_ovld = cyc;
            if (pop && first_pop < 0) first_pop = cyc;
            if (out_vld && out_rdy) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                delivered++; total_del++;
                last_xfer = cyc;
                if (first_xfer < 0) first_xfer = cyc;
            end
            popped_total += int'(pop);
            popped_ready += pop_d1;
            pop_d1 = int'(pop);
            check("outstanding", (popped_total - delivered) <= SD, 1);
            if (flush) begin
                flushing = 1; exp_q.delete(); done_cnt = 0;
            end
        end else begin
            check("out_vld_flush", out_vld, 0);
            check("pop_flush", pop, flush_done ? 1'b0 : !empty);
            if (flush_done) begin
                done_cnt++; done_cyc = cyc;
                if (!flush) begin
                    flushing = 0;
                    popped_ready = 0; popped_total = 0; delivered = 0; pop_d1 = 0;
                end
            end
        end
        if (pop && fifo_q.size() != 0) begin
            pend_vld  = 1;
            pend_data = fifo_q.pop_front();
            n_pops++;
        end
    endtask

    task automatic drain(input int maxc);
        for (int i = 0; i < maxc && (exp_q.size() != 0 || fifo_q.size() != 0); i++) cycle();
        check("drain_timeout", exp_q.size() + fifo_q.size(), 0);
    endtask

    task automatic wait_flush_end(input int maxc);
        for (int i = 0; i < maxc && flushing; i++) cycle();
        check("flush_timeout", flushing, 0);
    endtask

    task automatic do_reset();
        rst_n = 0; vld = 0; empty = 1; flush = 0; out_rdy = 0; data_out = '0;
        flush_req = 0; rdy_mode = 0;
        model_clear();
        total_del = 0;
        repeat (2) @(negedge rclk);
        rst_n = 1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; total_del = 0; n_pops = 0; rdy_limit = 0;
        model_clear();
        rst_n = 0; empty = 0; vld = 0; data_out = '0; flush = 0; out_rdy = 1;
        flush_req = 0; rdy_mode = 0;
        #3;
        check("rst_pop", pop, 0);
        check("rst_out_vld", out_vld, 0);
        check("rst_out_data", out_data, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_word_cnt", word_cnt, 0);

        // streaming
        do_reset();
        for (int i = 1; i <= 8; i++) load(DW'(i));
        rdy_mode = 0;
        drain(40);
        cycle();
        check("stream_latency", first_ovld - first_pop, 2);
        check("stream_span", last_xfer - first_xfer, 7);
        check("stream_cnt", word_cnt, 8);

        // backpressure
        do_reset();
        for (int i = 1; i <= 5; i++) load(DW'(i));
        rdy_mode = 1; n_pops = 0;
        repeat (8) cycle();
        check("bp_pops", n_pops, 2);
        check("bp_head", out_data, 1);
        check("bp_vld", out_vld, 1);
        rdy_mode = 0;
        drain(40);
        cycle();
        check("bp_cnt", word_cnt, 5);

        // alternating ready, 20 words: counter is 4 bits wide here so it saturates
        do_reset();
        for (int i = 0; i < 20; i++) load(DW'($urandom));
        rdy_mode = 2;
        drain(100);
        cycle();
        check("alt_cnt", word_cnt, CMAX);

        // single-cycle flush after 3 deliveries
        do_reset();
        for (int i = 1; i <= 10; i++) load(DW'(32'h100 + i));
        rdy_mode = 4; rdy_limit = 3;
        for (int i = 0; i < 30 && total_del < 3; i++) cycle();
        check("fl_pre_cnt", total_del, 3);
        flush_req = 1;
        cycle();
        flush_req = 0;
        check("fl_entered", flushing, 1);
        wait_flush_end(60);
        check("fl_done_cnt", done_cnt, 1);
        check("fl_word_cnt", word_cnt, 3);
        check("fl_fifo_empty", fifo_q.size(), 0);
        check("fl_after_vld", done_cyc > last_vld_cyc, 1);
        load(24'hABCDEF);
        rdy_mode = 0;
        drain(20);
        cycle();
        check("fl_new_word", word_cnt, 4);

        // sustained flush
        do_reset();
        for (int i = 0; i < 6; i++) load(DW'($urandom));
        rdy_mode = 0; flush_req = 1;
        repeat (8) cycle();
        for (int i = 0; i < 3; i++) load(DW'($urandom));
        repeat (20) cycle();
        check("sf_pulses", done_cnt >= 2, 1);
        check("sf_out_vld", out_vld, 0);
        flush_req = 0;
        wait_flush_end(40);
        check("sf_fifo_empty", fifo_q.size(), 0);

        // random traffic
        do_reset();
        rdy_mode = 3;
        repeat (300) begin
            if ($urandom_range(0, 2) == 0) load(DW'($urandom));
            cycle();
        end
        drain(200);

        // explicit saturation
        do_reset();
        for (int i = 0; i < 20; i++) load(DW'(i + 1));
        rdy_mode = 0;
        drain(60);
        cycle();
        check("sat_cnt", word_cnt, CMAX);

        // asynchronous reset mid-stream, then a stale vld after release
        do_reset();
        for (int i = 1; i <= 10; i++) load(DW'(i));
        rdy_mode = 0;
        repeat (5) cycle();
        #2 rst_n = 0;
        #1;
        check("mid_rst_pop", pop, 0);
        check("mid_rst_out_vld", out_vld, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_flush_done", flush_done, 0);
        check("mid_rst_word_cnt", word_cnt, 0);
        @(posedge rclk);
        #1 rst_n = 1;
        model_clear();
        total_del = 0;
        pend_vld = 1; pend_data = 24'hBADBAD;
        repeat (3) cycle();
        check("stale_vld_dropped", out_vld, 0);
        check("stale_word_cnt", word_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1);
    end
endmodule
